// File: rtl/be_axi_line_fill_pkg.sv
// Shared constants, state encoding and width helper for the AXI line-fill engine.
package be_axi_line_fill_pkg;

  // AXI burst types
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

  // AXI read response codes; bit 1 set means the beat carries an error
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Normal non-cacheable bufferable memory
  localparam logic [3:0] AXI_ARCACHE_DEF = 4'b0011;

  // Fill engine states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  // Bits needed to hold values 0..v-1, never less than one bit
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/be_axi_line_fill.sv
// Cache line-fill engine: one AXI4 read burst per replacement request, beats
// streamed straight into the line RAM, with RRESP retry and sticky error flag.
module be_axi_line_fill
  import be_axi_line_fill_pkg::*;
#(
  parameter int FE_ADDR_W  = 32,
  parameter int FE_DATA_W  = 32,
  parameter int BE_ADDR_W  = FE_ADDR_W,
  parameter int BE_DATA_W  = FE_DATA_W,
  parameter int WORD_OFF_W = 3,
  parameter int BURST_MODE = 0,
  parameter int MAX_RETRY  = 2,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ID     = 0,
  localparam int BE_BYTE_W  = $clog2(BE_DATA_W / 8),
  localparam int LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int LADDR_W    = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W
) (
  input  logic                  clk,
  input  logic                  reset,
  // cache_memory replacement request
  input  logic                  replace_valid,
  input  logic [LADDR_W-1:0]    replace_addr,
  input  logic [LINE2MEM_W-1:0] replace_woff,
  output logic                  replace_ready,
  // line RAM write port
  output logic                  read_valid,
  output logic [LINE2MEM_W-1:0] read_addr,
  output logic [BE_DATA_W-1:0]  read_rdata,
  // AXI4 AR channel
  output logic                  axi_arvalid,
  output logic [BE_ADDR_W-1:0]  axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic                  axi_arlock,
  output logic [3:0]            axi_arcache,
  output logic [2:0]            axi_arprot,
  output logic [3:0]            axi_arqos,
  output logic [AXI_ID_W-1:0]   axi_arid,
  input  logic                  axi_arready,
  // AXI4 R channel
  input  logic                  axi_rvalid,
  input  logic [BE_DATA_W-1:0]  axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  output logic                  axi_rready,
  // sticky error reporting
  output logic                  err,
  output logic [1:0]            err_resp,
  input  logic                  err_clr
);

  localparam int NBEATS  = 1 << LINE2MEM_W;
  localparam int RETRY_W = clog2_min1(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [LINE2MEM_W:0] LAST_TOTAL = (LINE2MEM_W + 1)'(NBEATS - 1);

  state_t                 state_q, state_d;
  logic [LADDR_W-1:0]     line_addr_q, line_addr_d;
  logic [LINE2MEM_W-1:0]  start_q, start_d;
  logic [LINE2MEM_W-1:0]  beat_cnt_q, beat_cnt_d;
  // One extra bit so overlong bursts are distinguishable; saturates at all-ones
  logic [LINE2MEM_W:0]    beat_tot_q, beat_tot_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic                   fill_err_q, fill_err_d;
  logic [1:0]             fill_resp_q, fill_resp_d;
  logic                   err_q, err_d;
  logic [1:0]             err_resp_q, err_resp_d;

  logic                   rbeat;
  logic                   in_line;
  logic                   proto_err;
  logic                   err_now;
  logic [1:0]             resp_now;
  logic                   new_err;
  logic [FE_ADDR_W-1:0]   fe_addr;

  // Beat qualifiers and running error status including the beat on the bus
  assign rbeat     = (state_q == DATA) && axi_rvalid;
  assign in_line   = ~beat_tot_q[LINE2MEM_W];
  assign proto_err = (beat_tot_q != LAST_TOTAL);
  assign err_now   = fill_err_q | axi_rresp[1];
  assign resp_now  = (axi_rresp[1] && (axi_rresp > fill_resp_q)) ? axi_rresp : fill_resp_q;

  // State register and datapath registers; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      start_q     <= '0;
      beat_cnt_q  <= '0;
      beat_tot_q  <= '0;
      retry_q     <= '0;
      fill_err_q  <= 1'b0;
      fill_resp_q <= AXI_RESP_OKAY;
      err_q       <= 1'b0;
      err_resp_q  <= AXI_RESP_OKAY;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      start_q     <= start_d;
      beat_cnt_q  <= beat_cnt_d;
      beat_tot_q  <= beat_tot_d;
      retry_q     <= retry_d;
      fill_err_q  <= fill_err_d;
      fill_resp_q <= fill_resp_d;
      err_q       <= err_d;
      err_resp_q  <= err_resp_d;
    end
  end

  // Next-state logic: request latch, AR handshake, beat counting, retry decision
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    start_d     = start_q;
    beat_cnt_d  = beat_cnt_q;
    beat_tot_d  = beat_tot_q;
    retry_d     = retry_q;
    fill_err_d  = fill_err_q;
    fill_resp_d = fill_resp_q;
    new_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (replace_valid) begin
          line_addr_d = replace_addr;
          start_d     = (BURST_MODE == 1) ? replace_woff : '0;
          fill_err_d  = 1'b0;
          fill_resp_d = AXI_RESP_OKAY;
          retry_d     = '0;
          state_d     = ADDR;
        end
      end

      ADDR: begin
        if (axi_arready) begin
          beat_cnt_d = start_q;
          beat_tot_d = '0;
          state_d    = DATA;
        end
      end

      DATA: begin
        if (axi_rvalid) begin
          // Counter wraps naturally at the line size, giving WRAP order
          beat_cnt_d  = beat_cnt_q + 1'b1;
          beat_tot_d  = (&beat_tot_q) ? beat_tot_q : beat_tot_q + 1'b1;
          fill_err_d  = err_now;
          fill_resp_d = resp_now;
          if (axi_rlast) begin
            if (proto_err) begin
              // Wrong beat count: the burst itself is broken, so never retried
              new_err = 1'b1;
              state_d = IDLE;
            end else if (err_now && (retry_q < RETRY_LIMIT)) begin
              retry_d     = retry_q + 1'b1;
              fill_err_d  = 1'b0;
              fill_resp_d = AXI_RESP_OKAY;
              state_d     = ADDR;
            end else begin
              new_err = err_now;
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Sticky error: a fresh error wins over a simultaneous clear
  always_comb begin
    err_d      = (err_q & ~err_clr) | new_err;
    err_resp_d = err_resp_q;
    if (new_err) begin
      err_resp_d = resp_now;
    end else if (err_clr) begin
      err_resp_d = AXI_RESP_OKAY;
    end
  end

  assign replace_ready = (state_q == IDLE);

  // Line RAM port follows the R channel with no added latency
  assign read_valid = rbeat && in_line;
  assign read_addr  = beat_cnt_q;
  assign read_rdata = axi_rdata;

  // AR channel, driven only from registers so fields stay stable until arready
  assign fe_addr     = {line_addr_q, start_q, {BE_BYTE_W{1'b0}}};
  assign axi_arvalid = (state_q == ADDR);
  assign axi_araddr  = BE_ADDR_W'(fe_addr);
  assign axi_arlen   = 8'(NBEATS - 1);
  assign axi_arsize  = 3'(BE_BYTE_W);
  assign axi_arburst = (BURST_MODE == 1) ? AXI_BURST_WRAP : AXI_BURST_INCR;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = AXI_ARCACHE_DEF;
  assign axi_arprot  = 3'b000;
  assign axi_arqos   = 4'b0000;
  assign axi_arid    = AXI_ID_W'(AXI_ID);

  assign axi_rready = (state_q == DATA);

  assign err      = err_q;
  assign err_resp = err_resp_q;

endmodule
